// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared constants and types for the multicycle sequencer.
//   - opcode constants (ir[15:13]), XZR register index
//   - instruction field bit positions
//   - FSM state enum and decoded opcode class
//   - sext_imm(): sign-extend the 7-bit immediate field to 16 bits
// Optional feature macro: MCTRL_HALT_EN (adds the HALT state).
package mctrl_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_CBZ  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;

  localparam logic [2:0] XZR = 3'd7;

  // Instruction fields:
  //   ADD : op[15:13] rm[12:10] ----[9:6] rn[5:3] rd[2:0]
  //   ADDI: op[15:13] imm7[12:6]          rn[5:3] rd[2:0]
  //   CBZ : op[15:13] off7[12:6]          ---     rt[2:0]
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RM_HI  = 12;
  localparam int RM_LO  = 10;
  localparam int IMM_HI = 12;
  localparam int IMM_LO = 6;
  localparam int RN_HI  = 5;
  localparam int RN_LO  = 3;
  localparam int RD_HI  = 2;
  localparam int RD_LO  = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

`ifdef MCTRL_HALT_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_t;
`endif

  typedef enum logic [1:0] {
    C_ADD  = 2'd0,
    C_ADDI = 2'd1,
    C_CBZ  = 2'd2,
    C_ILL  = 2'd3
  } op_cls_t;

  function automatic logic [15:0] sext_imm(input logic [15:0] i);
    return {{(16-IMM_W){i[IMM_HI]}}, i[IMM_HI:IMM_LO]};
  endfunction

endpackage

// File: rtl/mctrl_decode.sv
// mctrl_decode: purely combinational instruction decode from the latched ir.
// Ports:
//   ir       in  16 : latched instruction
//   cls      out 2  : opcode class (op_cls_t encoding)
//   raddr1   out 3  : rn for ADD/ADDI, rt for CBZ
//   raddr2   out 3  : rm
//   waddr    out 3  : rd
//   imm      out 16 : sign-extended ir[12:6]
//   halt_pat out 1  : CBZ XZR,#0 (branch-to-self on the zero register)
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  cls,
  output logic [2:0]  raddr1,
  output logic [2:0]  raddr2,
  output logic [2:0]  waddr,
  output logic [15:0] imm,
  output logic        halt_pat
);

  logic [2:0] op;
  assign op = ir[OP_HI:OP_LO];

  always_comb begin
    cls = C_ILL;
    case (op)
      OP_ADD:  cls = C_ADD;
      OP_ADDI: cls = C_ADDI;
      OP_CBZ:  cls = C_CBZ;
      default: cls = C_ILL;
    endcase
  end

  // CBZ tests rt, which sits in the rd slot.
  assign raddr1   = (op == OP_CBZ) ? ir[RD_HI:RD_LO] : ir[RN_HI:RN_LO];
  assign raddr2   = ir[RM_HI:RM_LO];
  assign waddr    = ir[RD_HI:RD_LO];
  assign imm      = sext_imm(ir);
  assign halt_pat = (op == OP_CBZ) && (ir[RD_HI:RD_LO] == XZR) &&
                    (ir[IMM_HI:IMM_LO] == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/WB sequencer for the 16-bit ARM-subset
// CPU. Owns PC and the instruction register and drives every datapath enable.
// Ports:
//   clock, reset_n (async, active low)
//   start     in  : begin at PC 0 from IDLE (or HALT)
//   stop      in  : go IDLE at the next instruction boundary, PC kept
//   iaddr     out : fetch address (= PC, registered)
//   idata     in  : instruction memory data
//   ir        out : latched instruction
//   rf_raddr1/rf_raddr2/rf_waddr out : register-file addresses (from ir)
//   rf_we     out : register-file write strobe (WB only, never for XZR)
//   alu_b_imm out : ALU operand B select (1 = imm)
//   imm       out : sign-extended ir[12:6]
//   rs_zero   in  : read-port-1 data is zero (sampled in EXEC)
//   busy      out : not IDLE/HALT
//   illegal   out : one-cycle pulse in EXEC of an undefined opcode
//   halted    out : in HALT (MCTRL_HALT_EN only, else 0)
// Optional feature macro: MCTRL_HALT_EN (CBZ XZR,#0 enters HALT).
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stop,
  output logic [PC_W-1:0] iaddr,
  input  logic [15:0]     idata,
  output logic [15:0]     ir,
  output logic [2:0]      rf_raddr1,
  output logic [2:0]      rf_raddr2,
  output logic [2:0]      rf_waddr,
  output logic            rf_we,
  output logic            alu_b_imm,
  output logic [15:0]     imm,
  input  logic            rs_zero,
  output logic            busy,
  output logic            illegal,
  output logic            halted
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [1:0]      cls_raw;
  op_cls_t         cls;
  logic            halt_pat;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;
  state_t          fetch_nxt;

  mctrl_decode u_dec (
    .ir       (ir),
    .cls      (cls_raw),
    .raddr1   (rf_raddr1),
    .raddr2   (rf_raddr2),
    .waddr    (rf_waddr),
    .imm      (imm),
    .halt_pat (halt_pat)
  );

  assign cls   = op_cls_t'(cls_raw);
  assign iaddr = pc;

  // Offsets are halfword counts relative to the branch's own address; all
  // PC arithmetic wraps modulo 2^PC_W and keeps bit 0 clear.
  assign pc_inc = pc + PC_W'(2);
  assign pc_br  = pc + {{(PC_W-IMM_W-1){imm[15]}}, imm[IMM_W-1:0], 1'b0};

  // Every way into FETCH honours stop and parks in IDLE instead.
  assign fetch_nxt = stop ? S_IDLE : S_FETCH;

`ifndef MCTRL_HALT_EN
  logic unused_halt;
  assign unused_halt = halt_pat;
  assign halted      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      rf_we     <= 1'b0;
      alu_b_imm <= 1'b0;
      busy      <= 1'b0;
      illegal   <= 1'b0;
`ifdef MCTRL_HALT_EN
      halted    <= 1'b0;
`endif
    end else begin
      rf_we   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= fetch_nxt;
            busy  <= ~stop;
          end
        end
        S_FETCH: begin
          ir    <= idata;
          state <= S_DECODE;
        end
        S_DECODE: begin
          // Operand select and illegal flag are valid for the whole EXEC cycle.
          alu_b_imm <= (cls == C_ADDI);
          illegal   <= (cls == C_ILL);
          state     <= S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            C_ADD, C_ADDI: begin
              // Writes to XZR are discarded by never raising the strobe.
              rf_we <= (rf_waddr != XZR);
              state <= S_WB;
            end
            C_CBZ: begin
`ifdef MCTRL_HALT_EN
              if (halt_pat) begin
                state  <= S_HALT;
                busy   <= 1'b0;
                halted <= 1'b1;
              end else begin
                pc    <= rs_zero ? pc_br : pc_inc;
                state <= fetch_nxt;
                busy  <= ~stop;
              end
`else
              pc    <= rs_zero ? pc_br : pc_inc;
              state <= fetch_nxt;
              busy  <= ~stop;
`endif
            end
            default: begin
              pc    <= pc_inc;
              state <= fetch_nxt;
              busy  <= ~stop;
            end
          endcase
        end
        S_WB: begin
          pc        <= pc_inc;
          alu_b_imm <= 1'b0;
          state     <= fetch_nxt;
          busy      <= ~stop;
        end
`ifdef MCTRL_HALT_EN
        S_HALT: begin
          // PC stays frozen on the halting CBZ until restarted.
          if (start) begin
            pc     <= '0;
            halted <= 1'b0;
            state  <= fetch_nxt;
            busy   <= ~stop;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl with a small
// behavioural register file/ALU and instruction memory.
module tb_multicycle_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic [15:0] iaddr;
  logic [15:0] idata;
  logic [15:0] ir;
  logic [2:0]  rf_raddr1;
  logic [2:0]  rf_raddr2;
  logic [2:0]  rf_waddr;
  logic        rf_we;
  logic        alu_b_imm;
  logic [15:0] imm;
  logic        rs_zero;
  logic        busy;
  logic        illegal;
  logic        halted;

  int n_chk = 0;
  int n_bad = 0;

  multicycle_ctrl #(.PC_W(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .iaddr     (iaddr),
    .idata     (idata),
    .ir        (ir),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_waddr  (rf_waddr),
    .rf_we     (rf_we),
    .alu_b_imm (alu_b_imm),
    .imm       (imm),
    .rs_zero   (rs_zero),
    .busy      (busy),
    .illegal   (illegal),
    .halted    (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // instruction memory, halfword addressed
  logic [15:0] imem [32];
  assign idata = (iaddr < 16'd64) ? imem[iaddr[5:1]] : 16'h0000;

  // register file / ALU model, X7 reads as zero
  logic [15:0] regs [8];
  logic [15:0] opa, opb;
  always_comb begin
    opa = (rf_raddr1 == 3'd7) ? 16'h0 : regs[rf_raddr1];
    opb = alu_b_imm ? imm : ((rf_raddr2 == 3'd7) ? 16'h0 : regs[rf_raddr2]);
  end
  assign rs_zero = (opa == 16'h0);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
    end else if (rf_we && rf_waddr != 3'd7) begin
      regs[rf_waddr] <= opa + opb;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".iaddr"},   iaddr,     0);
    chk({tag, ".ir"},      ir,        0);
    chk({tag, ".imm"},     imm,       0);
    chk({tag, ".rf_we"},   rf_we,     0);
    chk({tag, ".alu_b"},   alu_b_imm, 0);
    chk({tag, ".busy"},    busy,      0);
    chk({tag, ".illegal"}, illegal,   0);
    chk({tag, ".halted"},  halted,    0);
  endtask

  // Called on an instruction's FETCH cycle; leaves the bench on the next FETCH.
  task automatic run_ins(input string tag, input logic [15:0] addr, input int len,
                         input int we_exp, input int ill_exp);
    int we_n;
    int ill_n;
    we_n  = 0;
    ill_n = 0;
    chk({tag, ".iaddr"}, iaddr, addr);
    for (int c = 0; c < len; c++) begin
      if (rf_we)   we_n++;
      if (illegal) ill_n++;
      tick();
    end
    chk({tag, ".we_n"},  we_n,  we_exp);
    chk({tag, ".ill_n"}, ill_n, ill_exp);
  endtask

  task automatic load_a();
    for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    imem[0] = 16'hC0FA;  // ADDI X2,XZR,#3
    imem[1] = 16'h1C3C;  // ADD  X4,XZR,XZR
    imem[2] = 16'hBF82;  // CBZ  X2,-2
    imem[3] = 16'hC164;  // ADDI X4,X4,#5
    imem[4] = 16'hDFD2;  // ADDI X2,X2,#-1
    imem[5] = 16'hBF47;  // CBZ  XZR,-3
  endtask

  task automatic load_b();
    for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    imem[0] = 16'h080F;  // ADD  XZR,X1,X2
    imem[1] = 16'hE000;  // opcode 7
    imem[2] = 16'hC049;  // ADDI X1,X1,#1
    imem[3] = 16'hA007;  // CBZ  XZR,#0
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    load_a();
    repeat (2) tick();
    chk_rst("por");

    reset_n = 1'b1;
    repeat (2) tick();
    chk("idle.busy",  busy,  0);
    chk("idle.iaddr", iaddr, 0);

    // first instruction, cycle by cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c1.iaddr", iaddr, 16'h0);
    chk("c1.busy",  busy,  1);
    repeat (3) tick();
    chk("c4.rf_we",  rf_we,     1);
    chk("c4.waddr",  rf_waddr,  2);
    chk("c4.imm",    imm,       3);
    chk("c4.alu_b",  alu_b_imm, 1);
    tick();

    // multiply loop
    run_ins("add2", 16'h2, 4, 1, 0);
    for (int k = 0; k < 3; k++) begin
      run_ins("cbz4n", 16'h4, 3, 0, 0);
      run_ins("addi6", 16'h6, 4, 1, 0);
      run_ins("addi8", 16'h8, 4, 1, 0);
      run_ins("cbzA",  16'hA, 3, 0, 0);
    end
    run_ins("cbz4t", 16'h4, 3, 0, 0);
    chk("loop.iaddr", iaddr,   16'h0);
    chk("loop.x4",    regs[4], 15);
    chk("loop.x2",    regs[2], 0);

    // stop at the next boundary: ADDI at 0 completes, PC kept at 2
    stop = 1'b1;
    repeat (4) tick();
    chk("stop.busy",  busy,  0);
    chk("stop.iaddr", iaddr, 16'h2);
    stop = 1'b0;
    repeat (2) tick();
    chk("stop.hold", iaddr, 16'h2);

    // reset during EXEC of ADDI
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rx.c1", iaddr, 16'h0);
    repeat (2) tick();
    chk("rx.exec_alu_b", alu_b_imm, 1);
    chk("rx.exec_ir",    ir,        16'hC0FA);
    reset_n = 1'b0;
    #1;
    chk_rst("rx");
    tick();
    chk("rx.we1", rf_we, 0);
    tick();
    chk("rx.we2", rf_we, 0);
    load_b();
    reset_n = 1'b1;
    tick();

    // XZR write suppression and illegal opcode
    start = 1'b1;
    tick();
    start = 1'b0;
    run_ins("addz", 16'h0, 4, 0, 0);
    run_ins("ill",  16'h2, 3, 0, 1);
    run_ins("addi", 16'h4, 4, 1, 0);
    chk("b.x1", regs[1], 1);
    chk("b.iaddr6", iaddr, 16'h6);
`ifdef MCTRL_HALT_EN
    repeat (3) tick();
    chk("halt.halted", halted, 1);
    chk("halt.busy",   busy,   0);
    chk("halt.iaddr",  iaddr,  16'h6);
    repeat (3) tick();
    chk("halt.hold", iaddr,  16'h6);
    chk("halt.still", halted, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst.iaddr",  iaddr,  16'h0);
    chk("rst.halted", halted, 0);
    chk("rst.busy",   busy,   1);
`else
    run_ins("self1", 16'h6, 3, 0, 0);
    run_ins("self2", 16'h6, 3, 0, 0);
    chk("self.iaddr",  iaddr,  16'h6);
    chk("self.busy",   busy,   1);
    chk("self.halted", halted, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the 16-bit ARM-subset CPU. Owns the program counter, fetches from the combinational instruction memory, and holds each instruction in an instruction register. Decodes ADD/ADDI/CBZ and steps the register file and ALU through fetch, decode, execute and write-back. Sits between the instruction memory and the datapath; all datapath enables come from this block.

## Interface
- `PC_W`, 16: program counter / `iaddr` width.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins execution at PC 0 when idle.
- `stop` in 1: return to idle at the next instruction boundary.
- `iaddr` out PC_W: fetch address to instruction memory (= PC).
- `idata` in 16: instruction from instruction memory.
- `ir` out 16: latched instruction.
- `rf_raddr1` out 3: rn for ADD/ADDI, rt (`ir[2:0]`) for CBZ.
- `rf_raddr2` out 3: rm = `ir[12:10]`.
- `rf_waddr` out 3: rd = `ir[2:0]`.
- `rf_we` out 1: register-file write strobe.
- `alu_b_imm` out 1: 1 selects `imm` as ALU operand B.
- `imm` out 16: sign-extended `ir[12:6]`.
- `rs_zero` in 1: datapath flag, read-port-1 data == 0.
- `busy` out 1: not in IDLE/HALT.
- `illegal` out 1: one-cycle pulse on an undefined opcode.
- `halted` out 1: only with `MCTRL_HALT_EN`.

## Operation
- Opcodes are `ir[15:13]`: 0 = ADD, 5 = CBZ, 6 = ADDI. All others are illegal.
- States are IDLE, FETCH, DECODE, EXEC, WB, plus HALT when the macro is defined.
- IDLE: waits for `start`. On `start` it sets PC = 0 and moves to FETCH. `start` is ignored in all other states.
- FETCH: `iaddr` = PC; `ir` <= `idata` at the end of the cycle; next state is DECODE.
- DECODE: read addresses become valid from `ir`; next state is EXEC.
- EXEC, ADD/ADDI: hold the operands and move to WB. `alu_b_imm` = 1 for ADDI and 0 for ADD.
- EXEC, CBZ: if `rs_zero` = 1, PC <= PC + (sext(`ir[12:6]`) << 1); otherwise PC <= PC + 2. Next state is FETCH.
- EXEC, illegal: pulse `illegal`, set PC <= PC + 2, go to FETCH.
- WB: `rf_we` = 1 for one cycle, except it is forced to 0 when rd = 7 (XZR). PC <= PC + 2; next state is FETCH.
- Cycle counts: ADD/ADDI take 4 cycles; CBZ and illegal opcodes take 3.
- `stop` is sampled at every transition into FETCH. If it is high, the block goes to IDLE instead and keeps PC.
- PC arithmetic is modulo 2^PC_W and wraps silently. PC bit 0 is always 0.
- Branch offsets are relative to the CBZ's own address.

## Timing
- Reset values: PC = 0, state = IDLE, `iaddr` = 0, `ir` = 0, `imm` = 0, `rf_we` = 0, `alu_b_imm` = 0, `busy` = 0, `illegal` = 0, `halted` = 0.
- Reset asserted mid-instruction aborts immediately. No write strobe may fire after `reset_n` falls.
- `iaddr` and `ir` are registered. Decode outputs are combinational from `ir` only, never from `idata`.
- `rs_zero` is sampled only in EXEC.
- First FETCH occurs the cycle after `start` is sampled.

## Configuration
- `MCTRL_HALT_EN` defined:
  - CBZ with rt = 7 and offset 0 (branch-to-self on XZR) enters HALT in EXEC.
  - In HALT: `halted` = 1, `busy` = 0, PC is frozen.
  - HALT is left only by reset or by `start`, which restarts at PC 0.
- `MCTRL_HALT_EN` undefined:
  - That instruction is an ordinary taken CBZ and loops forever.
  - `halted` is tied to 0.

## Structure
- `mctrl_pkg` holds:
  - opcode constants `OP_ADD`, `OP_CBZ`, `OP_ADDI`;
  - `XZR` = 7;
  - the state enum;
  - field bit-position constants.
- Sub-module `mctrl_decode` is purely combinational. It takes `ir` and produces opcode class, the three register addresses, `imm` and the halt-pattern detect.
- The FSM and PC live in the top module.

## Test plan
The bench uses a behavioural register file/ALU model and a memory loaded with the 3×5 multiply loop (ADDI X2,XZR,#3; ADD X4,XZR,XZR; CBZ X2,-2; ADDI X4,X4,#5; ADDI X2,X2,#-1; CBZ XZR,-3).
- Reset, then `start`:
  - `iaddr` = 0 in cycle 1.
  - `rf_we` pulses in cycle 4 with `rf_waddr` = 2, `imm` = 3, `alu_b_imm` = 1.
- Run the loop:
  - CBZ at 0x4 is not taken three times (next `iaddr` 0x6), then taken to 0x0.
  - At that point the model holds X4 = 15 and X2 = 0.
  - CBZ at 0xA always branches to 0x4.
- Instruction ADD XZR,X1,X2: `rf_we` stays 0 through WB; PC advances by 2.
- Opcode 7 at 0x2: `illegal` is high for exactly one cycle; next fetch is at 0x4, 3 cycles after the previous fetch.
- Pulse `reset_n` low during EXEC of ADDI: all outputs return to their reset values immediately, and no `rf_we` is seen.
- With `MCTRL_HALT_EN`, CBZ XZR,#0 at 0x6 gives `halted` = 1 and `iaddr` held at 0x6. A following `start` refetches from 0x0.
- Without the macro, the same instruction refetches 0x6 every 3 cycles.
